reg_file_dump: RTL and testbench
================================

Name: reg_file_dump

Overview:
- Sequential read-side master for the 32x32 register file. Drives one read-address port and captures the combinational read data.
- On a start pulse, walks a contiguous (wrapping) address range and streams each register value out over a valid/ready interface.
- Used for debug dump and state inspection; sits beside the register file and shares a read port with the datapath via an external mux.

Parameters:
- DATA_WIDTH, 32, register width.
- ADDR_WIDTH, 5, register address width; address space is 2^ADDR_WIDTH entries.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- resetn  input  1  synchronous active-low reset.
- start  input  1  begin dump; sampled only in IDLE.
- first_addr  input  ADDR_WIDTH  first register to dump; latched on accepted start.
- last_addr  input  ADDR_WIDTH  final register to dump; latched on accepted start.
- raddr  output  ADDR_WIDTH  read address to the register file.
- rdata  input  DATA_WIDTH  combinational read data from the register file.
- out_valid  output  1  out_data/out_addr/out_last valid.
- out_ready  input  1  sink accepts the beat when high with out_valid.
- out_data  output  DATA_WIDTH  captured register value.
- out_addr  output  ADDR_WIDTH  address of out_data.
- out_last  output  1  beat is the last_addr entry.
- busy  output  1  dump in progress (FETCH, SEND or DONE).
- done  output  1  one-cycle pulse after the final beat is accepted.

Behaviour:
- Reset: resetn=0 at a rising edge -> state IDLE. All outputs 0 (raddr, out_*, busy, done), cur=0, latched range cleared. Reset takes priority in every state; a dump interrupted by reset emits no further beats and no done.
- States: IDLE, FETCH, SEND, DONE. Registered state and outputs; raddr=cur while not IDLE, 0 in IDLE.
- IDLE: start=1 -> latch first/last, cur<=first_addr, go to FETCH. start=0 -> stay.
- FETCH (1 cycle): raddr=cur. At the edge: out_data<=rdata, out_addr<=cur, out_last<=(cur==last), go to SEND.
- SEND: out_valid=1. out_data/out_addr/out_last held stable until handshake (out_valid & out_ready at an edge).
  - Handshake with out_last=0 -> cur<=cur+1 (mod 2^ADDR_WIDTH), go to FETCH.
  - Handshake with out_last=1 -> DONE.
  - No handshake -> stay in SEND.
- DONE (1 cycle): done=1, out_valid=0, then IDLE.
- Throughput: at most one beat per 2 cycles.
- Latency: start edge -> out_valid high 2 edges later. Final handshake -> done high the next cycle.
- Range and wrap:
  - Beat count = ((last-first) mod 2^ADDR_WIDTH)+1.
  - first>last wraps through the top address to 0 (e.g. 30,31,0,1).
  - first==last gives a single beat with out_last=1.
  - A full 32-entry dump needs last=first-1.
- Address 0: dumped like any other entry; data is whatever rdata returns (0 for the standard file).
- start while busy is ignored, including in DONE. start in the same cycle done=1 is also ignored.
- out_valid never deasserts before its handshake. out_ready while out_valid=0 has no effect.

Optional Feature:
- Macro: REG_FILE_DUMP_CHECKSUM_EN.
- Defined:
  - Adds output checksum [DATA_WIDTH-1:0].
  - Cleared to 0 on reset and on accepted start.
  - On each handshake, checksum<=checksum+out_data (mod 2^DATA_WIDTH).
  - Stable and final from the cycle done=1 until the next accepted start.
- Undefined: the port and logic are absent; all other behaviour is identical.

Test Plan:
1. Reset: hold resetn=0 for 3 cycles mid-run -> all outputs 0 next cycle, state IDLE, no done pulse.
2. Basic dump: r1=0x11, r2=0x22, r3=0x33, first=1, last=3, out_ready=1 -> beats (1,0x11), (2,0x22), (3,0x33,last) on every other cycle; done 1 cycle after third beat; checksum=0x66 if enabled.
3. Backpressure: same setup, out_ready=0 for 5 cycles when beat 2 appears -> out_valid stays 1, (2,0x22) held stable, no skipped or duplicated beat.
4. Wrap: r30=0xA, r31=0xB, r1=0xC, first=30, last=1 -> addrs 30,31,0,1 with data 0xA,0xB,0,0xC; last on addr 1.
5. Single beat and busy start: first=last=5, r5=0xDEADBEEF -> one beat with out_last=1; start pulses in FETCH/SEND/DONE are ignored, giving exactly one done.
6. Full range: first=0, last=31, random out_ready -> 32 beats in address order 0..31, data matching a model; busy low only after done.

Source files
------------

// File: rtl/reg_file_dump_if.sv
// Beat stream carrying dumped register values from reg_file_dump to its sink.
// The master drives valid/data/addr/last; the slave answers with ready.
interface reg_file_dump_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [ADDR_WIDTH-1:0] out_addr;
    logic                  out_last;

    modport master (
        output out_valid,
        input  out_ready,
        output out_data,
        output out_addr,
        output out_last
    );

    modport slave (
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_addr,
        input  out_last
    );
endinterface

// File: rtl/reg_file_dump.sv
// Sequential register-file reader: walks a wrapping address range and streams each value out.
// Optional running checksum of accepted beats when REG_FILE_DUMP_CHECKSUM_EN is defined.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; raddr held at 0
// S_FETCH | raddr=cur, capture rdata into the output beat at the edge
// S_SEND  | out_valid high, beat held until out_ready
// S_DONE  | one-cycle done pulse, then back to idle
module reg_file_dump #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] first_addr,
    input  logic [ADDR_WIDTH-1:0] last_addr,
    output logic [ADDR_WIDTH-1:0] raddr,
    input  logic [DATA_WIDTH-1:0] rdata,
    reg_file_dump_if.master       dump,
`ifdef REG_FILE_DUMP_CHECKSUM_EN
    output logic [DATA_WIDTH-1:0] checksum,
`endif
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_SEND  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_cur;
    logic [ADDR_WIDTH-1:0] r_last_addr;
    logic [ADDR_WIDTH-1:0] r_raddr;
    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_last;
    logic                  r_busy;
    logic                  r_done;
`ifdef REG_FILE_DUMP_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] r_checksum;
`endif

    logic                  w_hs;
    logic [ADDR_WIDTH-1:0] w_cur_next;

    assign w_hs       = r_valid & dump.out_ready;
    assign w_cur_next = r_cur + ADDR_WIDTH'(1);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_cur       <= '0;
            r_last_addr <= '0;
            r_raddr     <= '0;
            r_valid     <= 1'b0;
            r_data      <= '0;
            r_addr      <= '0;
            r_last      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
`ifdef REG_FILE_DUMP_CHECKSUM_EN
            r_checksum  <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_last_addr <= last_addr;
                        r_cur       <= first_addr;
                        r_raddr     <= first_addr;
                        r_busy      <= 1'b1;
`ifdef REG_FILE_DUMP_CHECKSUM_EN
                        r_checksum  <= '0;
`endif
                        r_state     <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    r_data  <= rdata;
                    r_addr  <= r_cur;
                    r_last  <= (r_cur == r_last_addr);
                    r_valid <= 1'b1;
                    r_state <= S_SEND;
                end
                S_SEND: begin
                    if (w_hs) begin
                        r_valid    <= 1'b0;
`ifdef REG_FILE_DUMP_CHECKSUM_EN
                        r_checksum <= r_checksum + r_data;
`endif
                        if (r_last) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            // Address increment wraps naturally through the top entry.
                            r_cur   <= w_cur_next;
                            r_raddr <= w_cur_next;
                            r_state <= S_FETCH;
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_raddr <= '0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign raddr          = r_raddr;
    assign dump.out_valid = r_valid;
    assign dump.out_data  = r_data;
    assign dump.out_addr  = r_addr;
    assign dump.out_last  = r_last;
    assign busy           = r_busy;
    assign done           = r_done;
`ifdef REG_FILE_DUMP_CHECKSUM_EN
    assign checksum       = r_checksum;
`endif

endmodule

// File: tb/tb_reg_file_dump.sv
// Directed bench for reg_file_dump: reset, basic, backpressure, wrap, single-beat and full-range dumps.
// Checksum checks are compiled in only when REG_FILE_DUMP_CHECKSUM_EN is defined.
module tb_reg_file_dump;

    logic        clk;
    logic        resetn;
    logic        start;
    logic [4:0]  first_addr;
    logic [4:0]  last_addr;
    logic [4:0]  raddr;
    logic [31:0] rdata;
    logic        busy;
    logic        done;
    logic [31:0] checksum_v;
    logic [31:0] regs [32];

    int total;
    int passed;

    reg_file_dump_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) u_if ();

    reg_file_dump #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) u_dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .first_addr (first_addr),
        .last_addr  (last_addr),
        .raddr      (raddr),
        .rdata      (rdata),
        .dump       (u_if.master),
`ifdef REG_FILE_DUMP_CHECKSUM_EN
        .checksum   (checksum_v),
`endif
        .busy       (busy),
        .done       (done)
    );

`ifndef REG_FILE_DUMP_CHECKSUM_EN
    assign checksum_v = '0;
`endif

    assign rdata = regs[raddr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic chk_beat(input string tag, input logic [4:0] a, input logic [31:0] d, input logic l);
        chk({tag, "_valid"}, 64'(u_if.out_valid), 64'(1'b1));
        chk({tag, "_addr"},  64'(u_if.out_addr),  64'(a));
        chk({tag, "_data"},  64'(u_if.out_data),  64'(d));
        chk({tag, "_last"},  64'(u_if.out_last),  64'(l));
    endtask

    // mode 0: always ready, mode 1: random ready. hold_start keeps start high while busy.
    task automatic run_dump(input string tag, input logic [4:0] f, input logic [4:0] l,
                            input int mode, input bit hold_start);
        logic [4:0]  diff;
        logic [4:0]  exp_a;
        logic [31:0] sum;
        int n, idx, dones, idle_bad;
        bit busy_drop;
        diff = l - f;
        n = int'(diff) + 1;
        idx = 0; dones = 0; sum = '0; busy_drop = 1'b0; idle_bad = 0;
        first_addr = f; last_addr = l; start = 1'b1;
        tick();
        start = hold_start;
        if (hold_start) begin
            first_addr = f + 5'd7;
            last_addr  = l + 5'd3;
        end
        for (int c = 0; c < 400 && dones == 0; c++) begin
            u_if.out_ready = (mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (!busy) busy_drop = 1'b1;
            if (u_if.out_valid && u_if.out_ready) begin
                exp_a = f + 5'(idx);
                chk({tag, "_addr"}, 64'(u_if.out_addr), 64'(exp_a));
                chk({tag, "_data"}, 64'(u_if.out_data), 64'(regs[exp_a]));
                chk({tag, "_last"}, 64'(u_if.out_last), 64'(idx == n - 1));
                sum = sum + regs[exp_a];
                idx++;
            end
            if (done) begin
                dones++;
                chk({tag, "_valid_in_done"}, 64'(u_if.out_valid), 64'(1'b0));
`ifdef REG_FILE_DUMP_CHECKSUM_EN
                chk({tag, "_checksum"}, 64'(checksum_v), 64'(sum));
`endif
            end
            tick();
        end
        start = 1'b0;
        chk({tag, "_done_seen"}, 64'(dones), 64'(1));
        chk({tag, "_beats"}, 64'(idx), 64'(n));
        chk({tag, "_busy_held"}, 64'(busy_drop), 64'(1'b0));
        chk({tag, "_busy_after"}, 64'(busy), 64'(1'b0));
        for (int c = 0; c < 4; c++) begin
            tick();
            if (u_if.out_valid || done || busy) idle_bad++;
        end
        chk({tag, "_quiet_after"}, 64'(idle_bad), 64'(0));
    endtask

    initial begin
        int bad;
        total = 0; passed = 0;
        resetn = 1'b0; start = 1'b0; first_addr = '0; last_addr = '0;
        u_if.out_ready = 1'b0;
        for (int i = 0; i < 32; i++) regs[i] = 32'h0100_0000 * 32'(i) + 32'h5A5 * 32'(i);
        regs[0] = 32'h0;
        regs[1] = 32'h11; regs[2] = 32'h22; regs[3] = 32'h33;
        tick(); tick();
        chk("rst_raddr", 64'(raddr), 64'(0));
        chk("rst_valid", 64'(u_if.out_valid), 64'(0));
        chk("rst_busy",  64'(busy), 64'(0));
        chk("rst_done",  64'(done), 64'(0));
        resetn = 1'b1;
        tick();

        // basic dump with fixed cycle-by-cycle expectations
        u_if.out_ready = 1'b1;
        first_addr = 5'd1; last_addr = 5'd3; start = 1'b1;
        tick();
        start = 1'b0;
        chk("basic_fetch_busy",  64'(busy), 64'(1));
        chk("basic_fetch_valid", 64'(u_if.out_valid), 64'(0));
        chk("basic_fetch_raddr", 64'(raddr), 64'(1));
        tick(); chk_beat("basic_b1", 5'd1, 32'h11, 1'b0);
        tick(); chk("basic_gap_valid", 64'(u_if.out_valid), 64'(0));
                chk("basic_gap_raddr", 64'(raddr), 64'(2));
        tick(); chk_beat("basic_b2", 5'd2, 32'h22, 1'b0);
        tick();
        tick(); chk_beat("basic_b3", 5'd3, 32'h33, 1'b1);
        tick();
        chk("basic_done",       64'(done), 64'(1));
        chk("basic_done_valid", 64'(u_if.out_valid), 64'(0));
        chk("basic_done_busy",  64'(busy), 64'(1));
`ifdef REG_FILE_DUMP_CHECKSUM_EN
        chk("basic_checksum", 64'(checksum_v), 64'(32'h66));
`endif
        tick();
        chk("basic_idle_done",  64'(done), 64'(0));
        chk("basic_idle_busy",  64'(busy), 64'(0));
        chk("basic_idle_raddr", 64'(raddr), 64'(0));

        // backpressure on beat 2
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); chk_beat("bp_b1", 5'd1, 32'h11, 1'b0);
        tick();
        u_if.out_ready = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk_beat("bp_hold", 5'd2, 32'h22, 1'b0);
            tick();
        end
        chk_beat("bp_hold_end", 5'd2, 32'h22, 1'b0);
        u_if.out_ready = 1'b1;
        tick(); chk("bp_after_valid", 64'(u_if.out_valid), 64'(0));
                chk("bp_after_raddr", 64'(raddr), 64'(3));
        tick(); chk_beat("bp_b3", 5'd3, 32'h33, 1'b1);
        tick(); chk("bp_done", 64'(done), 64'(1));
        tick();

        // wrap through the top address
        regs[30] = 32'hA; regs[31] = 32'hB; regs[1] = 32'hC;
        run_dump("wrap", 5'd30, 5'd1, 0, 1'b0);

        // single beat with start held high while busy
        regs[5] = 32'hDEADBEEF;
        run_dump("single", 5'd5, 5'd5, 0, 1'b1);

        // reset in the middle of a full dump
        u_if.out_ready = 1'b1;
        first_addr = 5'd0; last_addr = 5'd31; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        resetn = 1'b0;
        tick();
        chk("midrst_raddr", 64'(raddr), 64'(0));
        chk("midrst_valid", 64'(u_if.out_valid), 64'(0));
        chk("midrst_data",  64'(u_if.out_data), 64'(0));
        chk("midrst_addr",  64'(u_if.out_addr), 64'(0));
        chk("midrst_last",  64'(u_if.out_last), 64'(0));
        chk("midrst_busy",  64'(busy), 64'(0));
        chk("midrst_done",  64'(done), 64'(0));
`ifdef REG_FILE_DUMP_CHECKSUM_EN
        chk("midrst_checksum", 64'(checksum_v), 64'(0));
`endif
        tick(); tick();
        resetn = 1'b1;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (u_if.out_valid || done || busy) bad++;
        end
        chk("midrst_quiet", 64'(bad), 64'(0));

        // full range with random backpressure
        run_dump("full", 5'd0, 5'd31, 1, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
